modport_dut: RTL and testbench
==============================

# modport_dut

Registered six-transistor MOSFET current/transconductance sorter. Each cycle flagged by `valid`, it evaluates six NMOS devices from width and bias codes. It selects the three largest or three smallest results and presents their sum on `out_n`. It is the DUT behind the `mem_intf` driver/monitor modports.

## Interface
Parameters: none.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-low reset.
- `W_0`..`W_5` input 3 each: device width code, 0..7.
- `V_GS_0`..`V_GS_5` input 3 each: gate-source voltage code, 0..7.
- `V_DS_0`..`V_DS_5` input 3 each: drain-source voltage code, 0..7.
- `mode` input 2:
  - `mode[0]`: 1 = drain current Id, 0 = transconductance gm.
  - `mode[1]`: 1 = largest three, 0 = smallest three.
- `valid` input 1: inputs are meaningful in this cycle.
- `out_n` output 10: registered result.

## Operation
- Per device i, define overdrive `ov = V_GS - 1`. All arithmetic is unsigned. Every division by 3 truncates.
- Cutoff region, `V_GS <= 1`: Id = 0 and gm = 0.
- Triode region, `ov > V_DS`:
  - Id = W·(2·ov·V_DS − V_DS²)/3
  - gm = 2·W·V_DS/3
- Saturation region, otherwise:
  - Id = W·ov²/3
  - gm = 2·W·ov/3
- Per-device maximum values: Id ≤ 84, gm ≤ 28. Each fits in 7 bits.
- Sort the six selected values (Id or gm, per `mode[0]`).
  - `mode[1]`=1: result = sum of the three largest.
  - `mode[1]`=0: result = sum of the three smallest.
- Ties do not affect the result, because only the sum is output.
- Result is at most 252. It is zero-extended to 10 bits.

## Timing
- Reset: if `reset`=0 at a rising edge, `out_n` becomes 0 and any pipeline stage clears. This holds regardless of `valid`, including in the middle of an operation.
- Latency 1 (macro off): `valid`=1 sampled at edge k → `out_n` holds the result from edge k onward. Visible after edge k, and stable before edge k+1.
- `valid`=0: `out_n` holds its last value. Inputs are ignored.
- Back-to-back `valid` pulses: one result per cycle, throughput 1.
- Reset dominates a simultaneous `valid`=1.
- Datapath is combinational between registers. The design must close timing with a single adder/sort tree per stage.

## Configuration
- `MODPORT_INPUT_REG_EN` defined:
  - All input codes, `mode`, and `valid` are registered first.
  - Latency becomes 2 cycles; throughput stays 1 per cycle.
  - Reset clears the input stage, including its valid bit.
- Undefined: inputs feed the datapath combinationally, and latency is 1 cycle.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with random inputs and `valid`=1 → `out_n`=0. Release with `valid`=0 → `out_n` stays 0.
- Saturation sort, device i: W=i+1, V_GS=3, V_DS=3:
  - Per-device values: 1, 2, 4, 5, 6, 8 for both Id and gm.
  - mode=3 → 19; mode=1 → 7; mode=2 → 19; mode=0 → 7.
- Triode and cutoff mix:
  - Device 0: W=7, V_GS=7, V_DS=1, giving Id=25, gm=4.
  - Devices 1..5: V_GS=1, i.e. cutoff, giving 0.
  - mode=3 → 25; mode=2 → 4; mode=1 → 0.
- Maximum: all W=7, V_GS=7, V_DS=7 with mode=3 → 252, with no overflow.
- Hold and throughput:
  - Alternate two vectors on consecutive `valid`=1 cycles → the results follow at the documented latency.
  - Then hold `valid`=0 with changing inputs → `out_n` is unchanged.
- Mid-stream reset: assert `reset`=0 for one cycle during back-to-back traffic → `out_n`=0 the next cycle. No stale result appears after release.

Source files
------------

// File: rtl/modport_dut.sv
// Six-device NMOS Id/gm evaluator that registers the sum of the three largest or three smallest values.
// Define MODPORT_INPUT_REG_EN to add an input register stage, which gives a latency of 2.
module modport_dut (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] W_0,
    input  logic [2:0] W_1,
    input  logic [2:0] W_2,
    input  logic [2:0] W_3,
    input  logic [2:0] W_4,
    input  logic [2:0] W_5,
    input  logic [2:0] V_GS_0,
    input  logic [2:0] V_GS_1,
    input  logic [2:0] V_GS_2,
    input  logic [2:0] V_GS_3,
    input  logic [2:0] V_GS_4,
    input  logic [2:0] V_GS_5,
    input  logic [2:0] V_DS_0,
    input  logic [2:0] V_DS_1,
    input  logic [2:0] V_DS_2,
    input  logic [2:0] V_DS_3,
    input  logic [2:0] V_DS_4,
    input  logic [2:0] V_DS_5,
    input  logic [1:0] mode,
    input  logic       valid,
    output logic [9:0] out_n
);
    localparam int unsigned CODE_W = 3;
    localparam int unsigned VAL_W  = 7;
    localparam int unsigned SUM_W  = 10;
    localparam int unsigned N_DEV  = 6;
    localparam int unsigned RANK_W = 3;

    logic [N_DEV-1:0][CODE_W-1:0] w_in, vgs_in, vds_in;
    logic [N_DEV-1:0][CODE_W-1:0] w_s, vgs_s, vds_s;
    logic [1:0]                   mode_s;
    logic                         valid_s;

    assign w_in   = {W_5, W_4, W_3, W_2, W_1, W_0};
    assign vgs_in = {V_GS_5, V_GS_4, V_GS_3, V_GS_2, V_GS_1, V_GS_0};
    assign vds_in = {V_DS_5, V_DS_4, V_DS_3, V_DS_2, V_DS_1, V_DS_0};

`ifdef MODPORT_INPUT_REG_EN
    logic [N_DEV-1:0][CODE_W-1:0] w_d, vgs_d, vds_d, w_q, vgs_q, vds_q;
    logic [1:0]                   mode_d, mode_q;
    logic                         valid_d, valid_q;

    always_comb begin
        w_d     = w_in;
        vgs_d   = vgs_in;
        vds_d   = vds_in;
        mode_d  = mode;
        valid_d = valid;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q     <= '0;
            vgs_q   <= '0;
            vds_q   <= '0;
            mode_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            w_q     <= w_d;
            vgs_q   <= vgs_d;
            vds_q   <= vds_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
        end
    end

    assign w_s     = w_q;
    assign vgs_s   = vgs_q;
    assign vds_s   = vds_q;
    assign mode_s  = mode_q;
    assign valid_s = valid_q;
`else
    assign w_s     = w_in;
    assign vgs_s   = vgs_in;
    assign vds_s   = vds_in;
    assign mode_s  = mode;
    assign valid_s = valid;
`endif

    // Square-law device model. Triode never goes negative because vds < ov there.
    function automatic logic [VAL_W-1:0] dev_val(input logic [CODE_W-1:0] w,
                                                 input logic [CODE_W-1:0] vgs,
                                                 input logic [CODE_W-1:0] vds,
                                                 input logic              id_sel);
        logic [CODE_W-1:0] ov;
        logic [SUM_W-1:0]  wx, ox, dx, num;
        ov  = vgs - 3'd1;
        wx  = SUM_W'(w);
        ox  = SUM_W'(ov);
        dx  = SUM_W'(vds);
        num = '0;
        if (vgs <= 3'd1) begin
            num = '0;
        end else if (ov > vds) begin
            num = id_sel ? wx * (((ox * dx) << 1) - (dx * dx)) : (wx * dx) << 1;
        end else begin
            num = id_sel ? wx * ox * ox : (wx * ox) << 1;
        end
        return VAL_W'(num / SUM_W'(3));
    endfunction

    logic [N_DEV-1:0][VAL_W-1:0] vals;
    logic [N_DEV-1:0]            top_sel;
    logic [SUM_W-1:0]            total, top_sum, result;
    logic [RANK_W-1:0]           rank;

    // Rank each device and break ties by index, so that exactly three devices land in the top set.
    always_comb begin
        total   = '0;
        top_sum = '0;
        top_sel = '0;
        rank    = '0;
        for (int i = 0; i < int'(N_DEV); i++) begin
            vals[i] = dev_val(w_s[i], vgs_s[i], vds_s[i], mode_s[0]);
        end
        for (int i = 0; i < int'(N_DEV); i++) begin
            rank = '0;
            for (int j = 0; j < int'(N_DEV); j++) begin
                if (j != i) begin
                    if ((vals[j] > vals[i]) || ((vals[j] == vals[i]) && (j < i))) begin
                        rank = rank + 3'd1;
                    end
                end
            end
            top_sel[i] = (rank < 3'd3);
            total      = total + SUM_W'(vals[i]);
            top_sum    = top_sum + (top_sel[i] ? SUM_W'(vals[i]) : '0);
        end
        result = mode_s[1] ? top_sum : total - top_sum;
    end

    logic [SUM_W-1:0] out_d, out_q;

    always_comb begin
        out_d = out_q;
        if (valid_s) begin
            out_d = result;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out_n = out_q;
endmodule

// File: tb/tb_modport_dut.sv
// Scoreboard bench for modport_dut: a driver pushes the expected out_n for every edge, and a monitor compares at the falling edge.
module tb_modport_dut;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] w[6], vgs[6], vds[6];
    logic [1:0] mode;
    logic       valid;
    logic [9:0] out_n;

    always #5 clk = ~clk;

    modport_dut dut (
        .clk(clk), .reset(reset),
        .W_0(w[0]), .W_1(w[1]), .W_2(w[2]), .W_3(w[3]), .W_4(w[4]), .W_5(w[5]),
        .V_GS_0(vgs[0]), .V_GS_1(vgs[1]), .V_GS_2(vgs[2]),
        .V_GS_3(vgs[3]), .V_GS_4(vgs[4]), .V_GS_5(vgs[5]),
        .V_DS_0(vds[0]), .V_DS_1(vds[1]), .V_DS_2(vds[2]),
        .V_DS_3(vds[3]), .V_DS_4(vds[4]), .V_DS_5(vds[5]),
        .mode(mode), .valid(valid), .out_n(out_n)
    );

    int    exp_q[$];
    string name_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    int m_out = 0;
    bit m_sv  = 1'b0;
    int m_se  = 0;

    // Drive one edge, then push the out_n value that the edge should produce (the latency model only).
    task automatic step(input bit rst, input bit vld, input int e, input string nm);
        reset = rst;
        valid = vld;
        @(posedge clk);
`ifdef MODPORT_INPUT_REG_EN
        if (!rst) begin
            m_out = 0;
            m_sv  = 1'b0;
        end else begin
            if (m_sv) m_out = m_se;
            m_sv = vld;
        end
        m_se = e;
`else
        if (!rst) m_out = 0;
        else if (vld) m_out = e;
`endif
        exp_q.push_back(m_out);
        name_q.push_back(nm);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        int    e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (out_n !== 10'(e)) begin
                n_fail++;
                $display("FAIL %s: out_n=%0d expected %0d", nm, out_n, e);
            end
        end
    end

    task automatic set_rand();
        for (int i = 0; i < 6; i++) begin
            w[i]   = 3'($urandom);
            vgs[i] = 3'($urandom);
            vds[i] = 3'($urandom);
        end
        mode = 2'($urandom);
    endtask

    task automatic set_sat(input logic [1:0] m);
        for (int i = 0; i < 6; i++) begin
            w[i]   = 3'(i + 1);
            vgs[i] = 3'd3;
            vds[i] = 3'd3;
        end
        mode = m;
    endtask

    task automatic set_tri(input logic [1:0] m);
        for (int i = 1; i < 6; i++) begin
            w[i]   = 3'($urandom);
            vgs[i] = 3'($urandom_range(0, 1));
            vds[i] = 3'($urandom);
        end
        w[0] = 3'd7; vgs[0] = 3'd7; vds[0] = 3'd1;
        mode = m;
    endtask

    task automatic set_max(input logic [1:0] m);
        for (int i = 0; i < 6; i++) begin
            w[i] = 3'd7; vgs[i] = 3'd7; vds[i] = 3'd7;
        end
        mode = m;
    endtask

    initial begin
        reset = 1'b0;
        valid = 1'b0;
        set_rand();
        step(1'b0, 1'b1, 0, "reset_c0");
        set_rand();
        step(1'b0, 1'b1, 0, "reset_c1");
        set_rand();
        step(1'b1, 1'b0, 0, "release_0");
        step(1'b1, 1'b0, 0, "release_1");

        set_sat(2'd3); step(1'b1, 1'b1, 19, "sat_m3");
        set_sat(2'd1); step(1'b1, 1'b1, 7,  "sat_m1");
        set_sat(2'd2); step(1'b1, 1'b1, 19, "sat_m2");
        set_sat(2'd0); step(1'b1, 1'b1, 7,  "sat_m0");

        set_tri(2'd3); step(1'b1, 1'b1, 25, "tri_m3");
        set_tri(2'd2); step(1'b1, 1'b1, 4,  "tri_m2");
        set_tri(2'd1); step(1'b1, 1'b1, 0,  "tri_m1");
        set_tri(2'd0); step(1'b1, 1'b1, 0,  "tri_m0");

        set_max(2'd3); step(1'b1, 1'b1, 252, "max_m3");
        set_max(2'd1); step(1'b1, 1'b1, 252, "max_m1");
        set_max(2'd2); step(1'b1, 1'b1, 84,  "max_m2");
        set_max(2'd0); step(1'b1, 1'b1, 84,  "max_m0");

        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                set_sat(2'd3); step(1'b1, 1'b1, 19, "alt_sat");
            end else begin
                set_tri(2'd3); step(1'b1, 1'b1, 25, "alt_tri");
            end
        end
        for (int k = 0; k < 4; k++) begin
            set_rand(); step(1'b1, 1'b0, 0, "hold");
        end

        set_sat(2'd3); step(1'b1, 1'b1, 19,  "pre_rst_sat");
        set_tri(2'd3); step(1'b1, 1'b1, 25,  "pre_rst_tri");
        set_max(2'd3); step(1'b0, 1'b1, 252, "mid_rst");
        set_sat(2'd0); step(1'b1, 1'b1, 7,   "post_rst_sat");
        set_tri(2'd3); step(1'b1, 1'b1, 25,  "post_rst_tri");
        set_rand();    step(1'b1, 1'b0, 0,   "flush_0");
        set_rand();    step(1'b1, 1'b0, 0,   "flush_1");

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected values left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
